// File: rtl/ctrl_transmemory_rd.sv
// ctrl_transmemory_rd
//   Read-side controller for the transpose memory in the TQ path. After the write
//   controller reports a filled bank (i_wr_done), this block reads 1/2/8/32 rows
//   out of that bank, depending on the latched transform size. It drives the SRAM
//   read enable and address, and a 1-cycle-delayed valid strobe for the column
//   transform stage. One further finished block can wait in a pending slot, so
//   back-to-back blocks stream without an idle gap.
//
//   Optional feature macro: TRANS_RD_STALL_EN
//     defined   : i_ready gates ren and holds rd_addr while low
//     undefined : i_ready is ignored and READ issues ren every cycle
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous reset, active low
//   i_wr_done   in   1-cycle pulse: writer finished filling bank wr_bank
//   i_transize  in   [1:0] size of the block just written (00:1 01:2 10:8 11:32 rows)
//   i_ready     in   downstream ready (stall build only)
//   ren         out  transpose-memory read enable
//   rd_addr     out  [AW-1:0] row address within the bank
//   rd_bank     out  bank being read
//   wr_bank     out  bank the writer must fill next
//   o_valid     out  read data valid (ren delayed one cycle)
//   o_last      out  with o_valid: final row of the block
//   o_transize  out  [1:0] size of the block on the output
//   busy        out  reading, or a block is waiting in the pending slot
//   o_overflow  out  sticky: a write-done pulse was dropped (active and pending full)
module ctrl_transmemory_rd #(
    parameter int AW    = 5,
    parameter int BANKS = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_done,
    input  logic [1:0]    i_transize,
    input  logic          i_ready,
    output logic          ren,
    output logic [AW-1:0] rd_addr,
    output logic          rd_bank,
    output logic          wr_bank,
    output logic          o_valid,
    output logic          o_last,
    output logic [1:0]    o_transize,
    output logic          busy,
    output logic          o_overflow
);

    // The bank select is a single bit, so only a ping-pong pair is supported.
    if (BANKS != 2) begin : g_bank_check
        $error("ctrl_transmemory_rd supports exactly two banks");
    end

    typedef enum logic {IDLE, READ} state_t;

    state_t        state, state_n;
    logic [1:0]    size_q, size_n;
    logic [1:0]    pend_size, pend_size_n;
    logic          pend_vld, pend_vld_n;
    logic [AW-1:0] addr_n;
    logic          rd_bank_n, wr_bank_n, ovf_n;
    logic          go, at_last;

`ifdef TRANS_RD_STALL_EN
    assign go = i_ready;
`else
    logic unused_ready;
    assign unused_ready = i_ready;
    assign go = 1'b1;
`endif

    // Final row index for a given transform size.
    function automatic logic [AW-1:0] last_addr(input logic [1:0] sz);
        case (sz)
            2'b00:   return AW'(0);
            2'b01:   return AW'(1);
            2'b10:   return AW'(7);
            default: return AW'(31);
        endcase
    endfunction

    assign busy = (state != IDLE) || pend_vld;

    always_comb begin
        state_n     = state;
        size_n      = size_q;
        pend_size_n = pend_size;
        pend_vld_n  = pend_vld;
        addr_n      = rd_addr;
        rd_bank_n   = rd_bank;
        wr_bank_n   = wr_bank;
        ovf_n       = o_overflow;
        ren         = (state == READ) && go;
        at_last     = ren && (rd_addr == last_addr(size_q));

        case (state)
            IDLE: begin
                if (i_wr_done) begin
                    size_n    = i_transize;
                    rd_bank_n = wr_bank;
                    wr_bank_n = ~wr_bank;
                    addr_n    = '0;
                    state_n   = READ;
                end
            end
            READ: begin
                // A new block goes into the pending slot; if the slot is already
                // taken the pulse is lost and that is flagged permanently.
                if (i_wr_done) begin
                    if (pend_vld) begin
                        ovf_n = 1'b1;
                    end else begin
                        pend_vld_n  = 1'b1;
                        pend_size_n = i_transize;
                        wr_bank_n   = ~wr_bank;
                    end
                end
                if (ren) begin
                    addr_n = rd_addr + 1'b1;
                end
                if (at_last) begin
                    addr_n = '0;
                    if (pend_vld) begin
                        size_n     = pend_size;
                        rd_bank_n  = ~rd_bank;
                        pend_vld_n = 1'b0;
                    end else if (i_wr_done) begin
                        // Block arriving on the last row: it skips the slot and
                        // starts straight away on the next cycle.
                        size_n     = i_transize;
                        rd_bank_n  = ~rd_bank;
                        pend_vld_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            size_q     <= '0;
            pend_size  <= '0;
            pend_vld   <= 1'b0;
            rd_addr    <= '0;
            rd_bank    <= 1'b0;
            wr_bank    <= 1'b0;
            o_overflow <= 1'b0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_transize <= '0;
        end else begin
            state      <= state_n;
            size_q     <= size_n;
            pend_size  <= pend_size_n;
            pend_vld   <= pend_vld_n;
            rd_addr    <= addr_n;
            rd_bank    <= rd_bank_n;
            wr_bank    <= wr_bank_n;
            o_overflow <= ovf_n;
            // Output strobes follow ren by one cycle to line up with SRAM data.
            o_valid    <= ren;
            o_last     <= at_last;
            o_transize <= size_q;
        end
    end

endmodule
